// File: rtl/msi_pkg.sv
//------------------------------------------------------------------------------
// Module      : msi_pkg
// Description : Shared definitions for the MSI interrupt sender: the state
//               encoding and the default values of the sender parameters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package msi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } msi_state_e;

  localparam int unsigned HOLDOFF_CYCLES_DEFAULT = 1000;
  localparam int unsigned RDY_TIMEOUT_DEFAULT    = 4096;
  localparam logic [7:0]  MSI_VECTOR_DEFAULT     = 8'h00;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msi_timer.sv
//------------------------------------------------------------------------------
// Module      : msi_timer
// Description : Loadable down-counter. Load has priority over decrement; the
//               count stops at zero.
// Ports       : clk, resetn (sync, active-low), load_i/load_val_i (load),
//               dec_i (decrement enable), value_o (count), done_o (count==0)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module msi_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] value_o,
  output logic             done_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign done_o  = (value_q == '0);

endmodule

`default_nettype wire

// File: rtl/msi_irq_sender.sv
//------------------------------------------------------------------------------
// Module      : msi_irq_sender
// Description : Turns a level interrupt request into MSI requests towards a
//               PCIe core. After each grant a holdoff period is enforced; a
//               request still pending afterwards is re-sent, since MSI is
//               edge-signalled. Requests are aborted if the enables drop or
//               the core does not grant within RDY_TIMEOUT cycles.
// Ports       : clk, resetn (sync, active-low)
//               irq_req            in  level interrupt pending
//               irq_ack            out one-cycle pulse per accepted MSI
//               msi_enable         in  MSI Enable from config space
//               bus_master_en      in  Bus Master Enable from Command reg
//               cfg_interrupt      out MSI request (registered)
//               cfg_interrupt_rdy  in  core grant
//               cfg_interrupt_di   out MSI vector (constant MSI_VECTOR)
//               msi_sent_count     out granted MSI count (wraps)
//               err_timeout        out sticky grant-timeout flag
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module msi_irq_sender
  import msi_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT,
  parameter int unsigned RDY_TIMEOUT    = RDY_TIMEOUT_DEFAULT,
  parameter logic [7:0]  MSI_VECTOR     = MSI_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        irq_req,
  output logic        irq_ack,
  input  logic        msi_enable,
  input  logic        bus_master_en,
  output logic        cfg_interrupt,
  input  logic        cfg_interrupt_rdy,
  output logic [7:0]  cfg_interrupt_di,
  output logic [31:0] msi_sent_count,
  output logic        err_timeout
);

  // Both timers share one width, sized for the larger load value.
  localparam int unsigned MAX_LOAD = max_u(HOLDOFF_CYCLES, RDY_TIMEOUT) - 1;
  localparam int unsigned TMR_W    = $clog2(MAX_LOAD) + 1;

  msi_state_e  state_q, state_d;
  logic        cfg_q, cfg_d;
  logic        ack_q, ack_d;
  logic [31:0] msi_sent_count_q, msi_sent_count_d;
  logic        err_q, err_d;

  logic             ho_load, to_load;
  logic             ho_done, to_done;
  logic [TMR_W-1:0] ho_value, to_value;
  logic             unused_timer_bits;
  logic             enables_ok;

  assign enables_ok = msi_enable && bus_master_en;

  msi_timer #(.WIDTH(TMR_W)) u_holdoff_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (ho_load),
    .load_val_i (TMR_W'(HOLDOFF_CYCLES - 1)),
    .dec_i      (state_q == HOLDOFF),
    .value_o    (ho_value),
    .done_o     (ho_done)
  );

  msi_timer #(.WIDTH(TMR_W)) u_rdy_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (to_load),
    .load_val_i (TMR_W'(RDY_TIMEOUT - 1)),
    .dec_i      (state_q == ASSERT),
    .value_o    (to_value),
    .done_o     (to_done)
  );

  // Only the done flags steer the FSM; the raw counts are not needed here.
  assign unused_timer_bits = ^{ho_value, to_value};

  always_comb begin
    state_d          = state_q;
    cfg_d            = 1'b0;
    ack_d            = 1'b0;
    msi_sent_count_d = msi_sent_count_q;
    err_d            = err_q;
    ho_load          = 1'b0;
    to_load          = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_req && enables_ok) begin
          state_d = ASSERT;
          cfg_d   = 1'b1;
          to_load = 1'b1;
        end
      end
      ASSERT: begin
        // A grant wins over any abort condition seen on the same cycle.
        if (cfg_interrupt_rdy) begin
          state_d          = HOLDOFF;
          ack_d            = 1'b1;
          msi_sent_count_d = msi_sent_count_q + 32'd1;
          ho_load          = 1'b1;
        end else if (!enables_ok || to_done) begin
          state_d = IDLE;
          err_d   = err_q | to_done;
        end else begin
          cfg_d = 1'b1;
        end
      end
      HOLDOFF: begin
        if (ho_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= IDLE;
      cfg_q            <= 1'b0;
      ack_q            <= 1'b0;
      msi_sent_count_q <= 32'd0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      cfg_q            <= cfg_d;
      ack_q            <= ack_d;
      msi_sent_count_q <= msi_sent_count_d;
      err_q            <= err_d;
    end
  end

  assign cfg_interrupt    = cfg_q;
  assign irq_ack          = ack_q;
  assign msi_sent_count   = msi_sent_count_q;
  assign err_timeout      = err_q;
  assign cfg_interrupt_di = MSI_VECTOR;

endmodule

`default_nettype wire

// File: tb/tb_msi_irq_sender.sv
//------------------------------------------------------------------------------
// Module      : tb_msi_irq_sender
// Description : Self-checking bench for msi_irq_sender. Expected sent-counts
//               are queued when a grant is driven and compared whenever the
//               DUT pulses irq_ack.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_msi_irq_sender;

  logic        clk = 1'b0;
  logic        resetn;
  logic        irq_req;
  logic        irq_ack;
  logic        msi_enable;
  logic        bus_master_en;
  logic        cfg_interrupt;
  logic        cfg_interrupt_rdy;
  logic [7:0]  cfg_interrupt_di;
  logic [31:0] msi_sent_count;
  logic        err_timeout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_count;

  always #5 clk = ~clk;

  msi_irq_sender #(
    .HOLDOFF_CYCLES (8),
    .RDY_TIMEOUT    (16),
    .MSI_VECTOR     (8'hA5)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .irq_req           (irq_req),
    .irq_ack           (irq_ack),
    .msi_enable        (msi_enable),
    .bus_master_en     (bus_master_en),
    .cfg_interrupt     (cfg_interrupt),
    .cfg_interrupt_rdy (cfg_interrupt_rdy),
    .cfg_interrupt_di  (cfg_interrupt_di),
    .msi_sent_count    (msi_sent_count),
    .err_timeout       (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_grant();
    m_count = m_count + 32'd1;
    exp_q.push_back(m_count);
  endtask

  // Scoreboard: every ack must match a queued grant and carry its count.
  always @(negedge clk) begin
    if (resetn === 1'b1 && irq_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(irq_ack), 32'd0);
      end else begin
        check("ack_count", msi_sent_count, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn            = 1'b0;
    irq_req           = 1'b0;
    msi_enable        = 1'b0;
    bus_master_en     = 1'b0;
    cfg_interrupt_rdy = 1'b0;
    m_count           = 32'd0;
    repeat (3) tick();
    check("rst_cfg", 32'(cfg_interrupt), 32'd0);
    check("rst_ack", 32'(irq_ack), 32'd0);
    check("rst_cnt", msi_sent_count, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_di", 32'(cfg_interrupt_di), 32'hA5);

    // Enables low with request pending: stay idle, no error.
    resetn = 1'b1; irq_req = 1'b1; msi_enable = 1'b0; bus_master_en = 1'b1;
    repeat (6) tick();
    check("msien_low_cfg", 32'(cfg_interrupt), 32'd0);
    msi_enable = 1'b1; bus_master_en = 1'b0;
    repeat (6) tick();
    check("bme_low_cfg", 32'(cfg_interrupt), 32'd0);
    check("en_low_err", 32'(err_timeout), 32'd0);
    irq_req = 1'b0; bus_master_en = 1'b1;
    tick();

    // Single grant: request at cycle 0, grant at cycle 5, ack at cycle 6.
    irq_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sg_cfg", 32'(cfg_interrupt), 32'd1);
      check("sg_noack", 32'(irq_ack), 32'd0);
      if (i == 5) begin
        cfg_interrupt_rdy = 1'b1;
        expect_grant();
      end
    end
    tick();
    check("sg_cfg_drop", 32'(cfg_interrupt), 32'd0);
    check("sg_ack", 32'(irq_ack), 32'd1);
    check("sg_cnt", msi_sent_count, 32'd1);
    cfg_interrupt_rdy = 1'b0; irq_req = 1'b0;
    tick();
    check("sg_ack_pulse", 32'(irq_ack), 32'd0);

    // Request rises during holdoff (cycle 7); holdoff spans cycles 6-13,
    // so the re-request appears on cycle 15.
    irq_req = 1'b1;
    for (int c = 8; c <= 14; c++) begin
      tick();
      check("ho_cfg", 32'(cfg_interrupt), 32'd0);
    end
    tick();
    check("ho_rereq", 32'(cfg_interrupt), 32'd1);
    irq_req = 1'b0;
    tick();
    check("req_fall_hold1", 32'(cfg_interrupt), 32'd1);
    tick();
    check("req_fall_hold2", 32'(cfg_interrupt), 32'd1);
    cfg_interrupt_rdy = 1'b1;
    expect_grant();
    tick();
    check("req_fall_ack", 32'(irq_ack), 32'd1);
    check("req_fall_cfg", 32'(cfg_interrupt), 32'd0);
    cfg_interrupt_rdy = 1'b0;
    repeat (10) tick();

    // Re-trigger with rdy tied high: acks on cycles 2, 12, 22, 32, 42.
    irq_req = 1'b1; cfg_interrupt_rdy = 1'b1;
    for (int k = 0; k < 5; k++) expect_grant();
    for (int i = 1; i <= 50; i++) begin
      tick();
      check("rt_ack", 32'(irq_ack), (i >= 2 && (i - 2) % 10 == 0) ? 32'd1 : 32'd0);
      if (i == 45) begin
        irq_req = 1'b0; cfg_interrupt_rdy = 1'b0;
      end
    end
    check("rt_cnt", msi_sent_count, m_count);
    repeat (4) tick();

    // Grant on the same cycle as an enable drop is still a grant.
    irq_req = 1'b1;
    tick();
    check("prio_en_cfg", 32'(cfg_interrupt), 32'd1);
    irq_req = 1'b0; msi_enable = 1'b0; cfg_interrupt_rdy = 1'b1;
    expect_grant();
    tick();
    check("prio_en_ack", 32'(irq_ack), 32'd1);
    msi_enable = 1'b1; cfg_interrupt_rdy = 1'b0;
    repeat (10) tick();

    // Grant on the last cycle before timeout is still a grant.
    irq_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("prio_to_cfg", 32'(cfg_interrupt), 32'd1);
      if (i == 16) begin
        cfg_interrupt_rdy = 1'b1; irq_req = 1'b0;
        expect_grant();
      end
    end
    tick();
    check("prio_to_ack", 32'(irq_ack), 32'd1);
    check("prio_to_err", 32'(err_timeout), 32'd0);
    cfg_interrupt_rdy = 1'b0;
    repeat (10) tick();

    // Timeout: 16 cycles high, abort, error, re-request next idle cycle.
    irq_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("to_cfg", 32'(cfg_interrupt), 32'd1);
    end
    tick();
    check("to_cfg_drop", 32'(cfg_interrupt), 32'd0);
    check("to_noack", 32'(irq_ack), 32'd0);
    check("to_err", 32'(err_timeout), 32'd1);
    tick();
    check("to_rereq", 32'(cfg_interrupt), 32'd1);

    // Enable drop mid-assert: abort, no new request until re-enabled.
    msi_enable = 1'b0;
    tick();
    check("ed_cfg_drop", 32'(cfg_interrupt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ed_idle_cfg", 32'(cfg_interrupt), 32'd0);
    end
    check("ed_cnt", msi_sent_count, m_count);
    check("err_sticky", 32'(err_timeout), 32'd1);
    msi_enable = 1'b1;
    tick();
    check("ed_reenable_cfg", 32'(cfg_interrupt), 32'd1);
    cfg_interrupt_rdy = 1'b1; irq_req = 1'b0;
    expect_grant();
    tick();
    check("ed_ack", 32'(irq_ack), 32'd1);
    cfg_interrupt_rdy = 1'b0;
    repeat (10) tick();

    // Count wrap from all-ones to zero.
    force dut.msi_sent_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.msi_sent_count_q;
    tick();
    check("wrap_pre", msi_sent_count, 32'hFFFF_FFFF);
    m_count = 32'hFFFF_FFFF;
    irq_req = 1'b1;
    tick();
    check("wrap_cfg", 32'(cfg_interrupt), 32'd1);
    cfg_interrupt_rdy = 1'b1; irq_req = 1'b0;
    expect_grant();
    tick();
    check("wrap_cnt", msi_sent_count, 32'd0);
    cfg_interrupt_rdy = 1'b0;
    repeat (10) tick();

    // Reset in the middle of an assert.
    irq_req = 1'b1;
    repeat (3) tick();
    check("rm_cfg_pre", 32'(cfg_interrupt), 32'd1);
    resetn = 1'b0;
    tick();
    check("rm_cfg", 32'(cfg_interrupt), 32'd0);
    check("rm_ack", 32'(irq_ack), 32'd0);
    check("rm_cnt", msi_sent_count, 32'd0);
    check("rm_err", 32'(err_timeout), 32'd0);
    check("rm_di", 32'(cfg_interrupt_di), 32'hA5);
    m_count = 32'd0;
    irq_req = 1'b0; resetn = 1'b1;
    repeat (3) tick();
    check("rm_idle_cfg", 32'(cfg_interrupt), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
